// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller for the five-stage MIPS pipeline.
// Drives the IF/ID enable and flush select, the ID/EX and EX/MEM clears and
// the next-PC source. Sequences the multi-cycle mult/div unit with a 4-bit
// busy counter and runs a one-cycle REDIR state after an exception or eret.
//
// Acceptance rule for the mult/div unit (the only request/grant pair here):
// md_start_E acts as a "valid" and the unit is "ready" when busy = 0 and no
// exception is flushing E in the same cycle. A start is accepted only when
// both hold at the rising edge; a start offered while not ready is dropped
// rather than held, so the issuing stage must not rely on it being retried.
module pipe_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall_req_D,
    input  logic       md_use_D,
    input  logic       md_start_E,
    input  logic       md_div_E,
    input  logic       exc_req,
    input  logic       eret_M,
    output logic       en_PC,
    output logic       en_D,
    output logic       sel_D,
    output logic       clr_E,
    output logic       clr_M,
    output logic [1:0] pc_sel,
    output logic       busy
);

    // Next-PC source encodings.
    localparam logic [1:0] PC_SEQ     = 2'd0;  // PC+4 or branch target
    localparam logic [1:0] PC_HANDLER = 2'd1;  // exception handler 32'h00004180
    localparam logic [1:0] PC_EPC     = 2'd2;  // return address held in EPC

    // Busy-count load values, sized to the 4-bit counter.
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

    // RUN accepts redirect requests; REDIR is the single cycle right after a
    // redirect, during which exc_req and eret_M are ignored.
    typedef enum logic {
        RUN   = 1'b0,
        REDIR = 1'b1
    } state_t;

    // Current FSM state; kept as a named signal so checkers can bind to it.
    state_t     state;
    state_t     state_nxt;

    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    logic       exc_take;   // exception redirect taken this cycle
    logic       eret_take;  // eret redirect taken this cycle
    logic       md_accept;  // mult/div start accepted at the coming edge
    logic       md_stall;   // D uses mult/div while the unit is occupied
    logic       any_stall;  // either kind of D-stage stall

    assign busy = (cnt != 4'd0);

    // Redirects are only honoured in RUN; the exception outranks eret.
    assign exc_take  = (state == RUN) && exc_req;
    assign eret_take = (state == RUN) && eret_M && !exc_req;

    // A start is dropped while busy or while the E instruction is flushed.
    assign md_accept = md_start_E && !busy && !exc_req;

    // The issue cycle itself already stalls a dependent D instruction.
    assign md_stall  = md_use_D && (busy || md_start_E);
    assign any_stall = md_stall || stall_req_D;

    // State register; reset aborts any REDIR in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control outputs, with normal-run values as defaults.
    always_comb begin
        state_nxt = state;
        en_PC     = 1'b1;
        en_D      = 1'b1;
        sel_D     = 1'b0;
        clr_E     = 1'b0;
        clr_M     = 1'b0;
        pc_sel    = PC_SEQ;

        case (state)
            RUN: begin
                if (exc_req || eret_M) begin
                    state_nxt = REDIR;
                end
            end
            REDIR: begin
                state_nxt = RUN;
            end
        endcase

        if (reset) begin
            // Normal-run values while reset is applied.
            state_nxt = RUN;
        end else if (exc_take) begin
            // Flush F, D, E and M; the flush writes through, so enables stay 1.
            sel_D  = 1'b1;
            clr_E  = 1'b1;
            clr_M  = 1'b1;
            pc_sel = PC_HANDLER;
        end else if (eret_take) begin
            // eret itself is in M and completes, so EX/MEM is not cleared.
            sel_D  = 1'b1;
            clr_E  = 1'b1;
            pc_sel = PC_EPC;
        end else if (any_stall) begin
            // Hold PC and IF/ID, inject a bubble into E.
            en_PC = 1'b0;
            en_D  = 1'b0;
            clr_E = 1'b1;
        end
    end

    // Busy counter next value: load on an accepted start, else count down.
    always_comb begin
        cnt_nxt = cnt;
        if (md_accept) begin
            cnt_nxt = md_div_E ? DIV_LOAD : MULT_LOAD;
        end else if (cnt != 4'd0) begin
            cnt_nxt = cnt - 4'd1;
        end
    end

    // Busy counter register; exceptions leave a running count alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random stimulus for pipe_ctrl, checked by a
// scoreboard against a cycle-number based reference model.
module tb_pipe_ctrl;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic       clk;
    logic       reset;
    logic       stall_req_D;
    logic       md_use_D;
    logic       md_start_E;
    logic       md_div_E;
    logic       exc_req;
    logic       eret_M;
    logic       en_PC;
    logic       en_D;
    logic       sel_D;
    logic       clr_E;
    logic       clr_M;
    logic [1:0] pc_sel;
    logic       busy;

    pipe_ctrl #(
        .MULT_CYC(MULT_CYC),
        .DIV_CYC (DIV_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall_req_D(stall_req_D),
        .md_use_D   (md_use_D),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .exc_req    (exc_req),
        .eret_M     (eret_M),
        .en_PC      (en_PC),
        .en_D       (en_D),
        .sel_D      (sel_D),
        .clr_E      (clr_E),
        .clr_M      (clr_M),
        .pc_sel     (pc_sel),
        .busy       (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    // Packed as {en_PC, en_D, sel_D, clr_E, clr_M, pc_sel[1:0], busy}.
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    // ---------------- reference model ----------------
    // cyc numbers clock cycles. The unit is busy during cycle c when
    // c <= busy_end; REDIR is active only in cycle redir_cyc.
    int cyc       = 0;
    int busy_end  = -1;
    int redir_cyc = -1;

    function automatic logic [7:0] pack(input logic p, input logic d, input logic s,
                                        input logic e, input logic m,
                                        input logic [1:0] ps, input logic b);
        return {p, d, s, e, m, ps, b};
    endfunction

    // Drive one cycle of inputs, predict the outputs, advance the model.
    task automatic step(input logic rst, input logic stl, input logic use_d,
                        input logic start, input logic div, input logic exc,
                        input logic eret, input logic chk);
        logic       b;
        logic       in_redir;
        logic [7:0] e;
        reset       = rst;
        stall_req_D = stl;
        md_use_D    = use_d;
        md_start_E  = start;
        md_div_E    = div;
        exc_req     = exc;
        eret_M      = eret;

        b        = (cyc <= busy_end);
        in_redir = (cyc == redir_cyc);

        if (rst)
            e = pack(1, 1, 0, 0, 0, 2'd0, b);
        else if (!in_redir && exc)
            e = pack(1, 1, 1, 1, 1, 2'd1, b);
        else if (!in_redir && eret)
            e = pack(1, 1, 1, 1, 0, 2'd2, b);
        else if ((use_d && (b || start)) || stl)
            e = pack(0, 0, 0, 1, 0, 2'd0, b);
        else
            e = pack(1, 1, 0, 0, 0, 2'd0, b);

        if (chk) begin
            exp_q.push_back(e);
            exp_cyc_q.push_back(cyc);
        end

        if (rst) begin
            busy_end  = -1;
            redir_cyc = -1;
        end else begin
            if (start && !b && !exc)
                busy_end = cyc + (div ? DIV_CYC : MULT_CYC);
            if (!in_redir && (exc || eret))
                redir_cyc = cyc + 1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic use_d);
        for (int i = 0; i < n; i++) step(0, 0, use_d, 0, 0, 0, 0, 1);
    endtask

    // ---------------- monitor ----------------
    // Every cycle presents a full output vector; compare it mid-cycle.
    always @(negedge clk) begin
        logic [7:0] got;
        logic [7:0] exp;
        int         ec;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            ec  = exp_cyc_q.pop_front();
            got = {en_PC, en_D, sel_D, clr_E, clr_M, pc_sel, busy};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d got {en_PC,en_D,sel_D,clr_E,clr_M,pc_sel,busy}=%b required %b",
                         ec, got, exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Unchecked first edge clears the uninitialised state.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // Reset held 2 cycles, then idle.
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        idle(4, 0);

        // mult issue with dependent instruction held in D.
        step(0, 0, 1, 1, 0, 0, 0, 1);
        idle(MULT_CYC + 2, 1);
        idle(2, 0);

        // div issue, then a second start at busy cycle 3 (not reloaded).
        step(0, 0, 1, 1, 1, 0, 0, 1);
        idle(2, 1);
        step(0, 0, 1, 1, 1, 0, 0, 1);
        idle(DIV_CYC, 1);
        idle(2, 0);

        // Reset wins over stall and exception inputs.
        step(1, 1, 1, 1, 0, 1, 1, 1);
        idle(1, 0);

        // Exception together with a stall, then a repeated request in REDIR.
        step(0, 1, 0, 0, 0, 1, 0, 1);
        step(0, 1, 0, 0, 0, 1, 0, 1);
        idle(2, 0);

        // eret in RUN, then eret together with exception; eret with a stall.
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        idle(1, 0);
        step(0, 0, 0, 0, 0, 1, 1, 1);
        idle(1, 0);
        step(0, 1, 1, 0, 0, 0, 1, 1);
        idle(1, 0);

        // Start offered with an exception is dropped; a running count survives one.
        step(0, 0, 1, 1, 0, 1, 0, 1);
        idle(2, 1);
        step(0, 0, 0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 1);
        idle(MULT_CYC, 1);

        // Reset at busy cycle 4 of a div.
        step(0, 0, 0, 1, 1, 0, 0, 1);
        idle(3, 1);
        step(1, 0, 1, 0, 0, 0, 0, 1);
        idle(3, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic r, s, u, st, dv, ex, er;
            r  = ($urandom_range(0, 79) == 0);
            s  = ($urandom_range(0, 3) == 0);
            u  = ($urandom_range(0, 2) == 0);
            st = ($urandom_range(0, 5) == 0);
            dv = $urandom_range(0, 1);
            ex = ($urandom_range(0, 15) == 0);
            er = ($urandom_range(0, 15) == 0);
            step(r, s, u, st, dv, ex, er, 1);
        end
        idle(2, 0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
